// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receiver. The
//               UART_RX_PARITY_EN macro adds the PARITY state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Sub-bit ticks per bit time
  localparam int OVERSAMPLE = 16;

  // Parity sense when parity is compiled in: 0 = even, 1 = odd
  localparam logic PARITY_ODD = 1'b0;

  // Receiver FSM states; encodings are fixed so that both builds agree
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Small synchronous FIFO with ready-valid on both sides.
//               A write into a full FIFO is accepted when a pop happens in
//               the same cycle, since the popped slot is the one written.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  // Pointers carry one extra bit so that full and empty differ only in the MSB
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid_o = !empty_o;
  assign in_ready_o  = !full_o || out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Read/write pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage; cleared on reset so the head reads 0 while empty after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
    end
  end

endmodule : uart_fifo
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 16x oversampling with mid-bit sampling,
//               framing/parity error pulses and a receive FIFO behind a
//               ready-valid output. Define UART_RX_PARITY_EN to add a parity
//               bit between the data bits and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int         DIV     = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int         CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] OS_HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_END = 4'(DATA_BITS - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx: CLK_FREQ too low for 16x oversampling at BAUD_RATE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
      $error("uart_rx: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_rx: FIFO_DEPTH must be a power of 2, at least 2");
    end
  endgenerate

  logic                 rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 tick;
  uart_rx_state_t       state_q, state_d;
  logic [3:0]           os_q, os_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push;
  logic                 fifo_in_ready, fifo_full, fifo_empty;
  logic                 unused_fifo_flags;

  // Two-flop synchronizer on the asynchronous line; idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversample tick divider
  assign tick = (cnt_q == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CNT_W'(1);
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      os_q         <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      os_q         <= os_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic; the FIFO push is issued in the stop-sample cycle itself
  always_comb begin
    state_d      = state_q;
    os_d         = os_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && !rx_s_q) begin
          os_d      = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == OS_HALF) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              os_d    = '0;
              state_d = DATA;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == OS_LAST) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 4'd1;
            if (bit_q == BIT_END) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == OS_LAST) begin
            if (((^shift_q) ^ rx_s_q) != PARITY_ODD) begin
              par_bad_d    = 1'b1;
              parity_err_d = 1'b1;
            end
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == OS_LAST) begin
            if (rx_s_q) begin
              if (!par_bad_q) begin
                if (fifo_in_ready) push = 1'b1;
                else               overrun_d = 1'b1;
              end
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (push),
    .in_data_i   (shift_q),
    .in_ready_o  (fifo_in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign unused_fifo_flags = &{1'b0, fifo_full, fifo_empty};

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx at 16 clk per bit.
//               Define UART_RX_PARITY_EN to exercise the parity build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_err, parity_err, overrun;

  int total = 0;
  int bad   = 0;

  // Monitor state
  logic [7:0] rcv[$];
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, valid_cyc = 0;

  uart_rx #(
    .CLK_FREQ   (1_843_200),
    .BAUD_RATE  (115200),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
    if (out_valid)  valid_cyc++;
    if (out_valid && out_ready) rcv.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rcv_at(input int i);
    if (i < rcv.size()) return rcv[i];
    return 8'hxx;
  endfunction

  // One frame: start, 8 data bits LSB first, optional parity, stop.
  // stop_low > 0 holds the stop bit low for that many bit times first.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input logic par);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (16) @(negedge clk);
`else
    if (par === 1'bz) rx = 1'b1;
`endif
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (16 * stop_low) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  int base_n, base_fe, base_pe, base_ov, base_v;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_out_data",   {24'd0, out_data},   32'd0);
    check("rst_frame_err",  {31'd0, frame_err},  32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_overrun",    {31'd0, overrun},    32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Clean frame 0xA5 with consumer ready
    base_n = rcv.size(); base_fe = fe_cnt; base_pe = pe_cnt; base_ov = ov_cnt; base_v = valid_cyc;
    send_frame(8'hA5, 0, even_par(8'hA5));
    repeat (5) @(negedge clk);
    check("a5_count",      rcv.size() - base_n,  32'd1);
    check("a5_data",       {24'd0, rcv_at(base_n)}, 32'hA5);
    check("a5_valid_cyc",  valid_cyc - base_v,   32'd1);
    check("a5_no_errs",    (fe_cnt - base_fe) + (pe_cnt - base_pe) + (ov_cnt - base_ov), 32'd0);

    // Short low glitch on idle line
    base_n = rcv.size(); base_fe = fe_cnt; base_ov = ov_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_push",  rcv.size() - base_n, 32'd0);
    check("glitch_no_pulse", (fe_cnt - base_fe) + (ov_cnt - base_ov), 32'd0);
    check("glitch_empty",    {31'd0, out_valid}, 32'd0);

    // Framing error: stop bit low for 3 bit times, then recovery
    base_n = rcv.size(); base_fe = fe_cnt;
    send_frame(8'h3C, 3, even_par(8'h3C));
    repeat (5) @(negedge clk);
    check("fe_pulse",   fe_cnt - base_fe,     32'd1);
    check("fe_no_push", rcv.size() - base_n,  32'd0);
    check("fe_empty",   {31'd0, out_valid},   32'd0);
    repeat (20) @(negedge clk);
    send_frame(8'h01, 0, even_par(8'h01));
    repeat (5) @(negedge clk);
    check("fe_recover_count", rcv.size() - base_n, 32'd1);
    check("fe_recover_data",  {24'd0, rcv_at(base_n)}, 32'h01);

    // Overrun: five frames into a 4-deep FIFO with consumer stalled
    out_ready = 1'b0;
    base_n = rcv.size(); base_ov = ov_cnt;
    for (int k = 0; k < 5; k++) send_frame(8'h10 + 8'(k), 0, even_par(8'h10 + 8'(k)));
    repeat (5) @(negedge clk);
    check("ovr_pulse",      ov_cnt - base_ov,    32'd1);
    check("ovr_valid",      {31'd0, out_valid},  32'd1);
    check("ovr_head_hold",  {24'd0, out_data},   32'h10);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ovr_drain_count", rcv.size() - base_n, 32'd4);
    for (int k = 0; k < 4; k++)
      check("ovr_drain_data", {24'd0, rcv_at(base_n + k)}, 32'h10 + 32'(k));
    check("ovr_drained_empty", {31'd0, out_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    base_n = rcv.size(); base_pe = pe_cnt;
    send_frame(8'h07, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("par_bad_pulse",   pe_cnt - base_pe,    32'd1);
    check("par_bad_no_push", rcv.size() - base_n, 32'd0);
    send_frame(8'h07, 0, 1'b1);
    repeat (5) @(negedge clk);
    check("par_good_count", rcv.size() - base_n, 32'd1);
    check("par_good_data",  {24'd0, rcv_at(base_n)}, 32'h07);
    check("par_good_no_pe", pe_cnt - base_pe,    32'd1);
`endif

    // Reset mid-frame with a character waiting in the FIFO
    out_ready = 1'b0;
    send_frame(8'h33, 0, even_par(8'h33));
    repeat (5) @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_data",  {24'd0, out_data},  32'h33);
    rx = 1'b0;                       // start bit
    repeat (16) @(negedge clk);
    rx = 1'b1;                       // data bits 0,1 of 0x77
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data",  {24'd0, out_data},  32'd0);
    check("mid_rst_errs",  {29'd0, frame_err, parity_err, overrun}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    base_n = rcv.size();
    send_frame(8'h5A, 0, even_par(8'h5A));
    repeat (5) @(negedge clk);
    check("post_rst_count", rcv.size() - base_n, 32'd1);
    check("post_rst_data",  {24'd0, rcv_at(base_n)}, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Parametrised UART receiver with 16x oversampling, mid-bit sampling, framing-error detection and a small receive FIFO behind a ready-valid output. It is the receive half of the UART main interface, generalised in character width, baud divisor and buffering depth. It sits between the board-level `rx` pin and any byte-stream consumer (command parser, DMA).

## Interface
- `CLK_FREQ`, 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `DATA_BITS`, 8: character width, legal range 5–9.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of 2, at least 2.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: asynchronous serial line; idles high.
- `out_data`, output, DATA_BITS: head-of-FIFO character, LSB = first bit received.
- `out_valid`, output, 1: FIFO non-empty.
- `out_ready`, input, 1: consumer accepts `out_data`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`, output, 1: one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.
- `overrun`, output, 1: one-cycle pulse when a good character arrives while the FIFO is full.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`) that resets to 1.
- Tick generator:
  - `DIV = CLK_FREQ / (BAUD_RATE*16)`, integer division; elaboration error if DIV < 1.
  - Counter counts 0..DIV-1 and pulses `tick` on wrap.
  - The counter free-runs in every state.
- States (enum in the package): IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when `tick` and `rx_s`=0, clear the sub-bit counter `os` (4 bits) and go to START.
  - START: on `tick`, `os++`. At `os`=7:
    - if `rx_s`=1 (glitch), go to IDLE;
    - otherwise clear `os` and go to DATA.
  - DATA: on `tick`, `os++`. At `os`=15:
    - shift `rx_s` in LSB-first and increment the bit counter;
    - after DATA_BITS bits, go to PARITY if enabled, otherwise STOP.
  - PARITY: sample at `os`=15, then go to STOP.
  - STOP: sample at `os`=15.
    - `rx_s`=1: if FIFO not full, push the character; if full, pulse `overrun` and drop the new character. Go to IDLE.
    - `rx_s`=0: pulse `frame_err`, discard the character, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1 (break condition), then go to IDLE.
  - Illegal state encoding: go to IDLE.
- A parity error pulses `parity_err` and discards the character. The STOP check still runs, and both error pulses may fire for the same frame.
- FIFO rules:
  - Pop when `out_valid && out_ready`.
  - Simultaneous push and pop while full: pop wins, the push is accepted, and no overrun is raised.
  - Simultaneous push and pop while empty: the push lands and `out_valid` rises on the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are taken from the pointer MSB compare.

## Timing
- Reset values:
  - `out_valid`, `frame_err`, `parity_err`, `overrun` = 0.
  - `out_data` = 0.
  - state = IDLE; counters and pointers = 0.
- Reset mid-frame aborts the character. After release the block waits in IDLE for the next falling edge.
- Input latency: 2 clk through the synchronizer.
- Sample instants:
  - Start-bit check at 8 ticks after the detected falling edge (mid-bit).
  - Each data bit 16 ticks after the previous sample.
- Output latency: `out_valid` rises 1 clk after the STOP-sample cycle.
- `out_data` is stable while `out_valid && !out_ready`.
- Error and overrun pulses are asserted in the cycle after the STOP (or PARITY) sample and last exactly 1 clk.
- Throughput: back-to-back frames are accepted. IDLE re-arms on the tick following the STOP sample, which is half a bit before the nominal stop-bit end.

## Configuration
- `UART_RX_PARITY_EN`, macro defined:
  - The PARITY state is present.
  - Package parameter `PARITY_ODD` (0 = even, 1 = odd) selects the check.
  - The frame is start + DATA_BITS + parity + stop.
- Macro undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `parity_err` is tied 0.

## Structure
- Package `uart_pkg` holds:
  - the `uart_rx_state_t` enum;
  - the oversampling constant `OVERSAMPLE = 16`;
  - `PARITY_ODD`.
- The FIFO is the sub-module `uart_fifo`, parameterised on WIDTH and DEPTH. It has ready-valid on both sides and reports `full` and `empty`.
- The synchronizer, tick generator and FSM live in `uart_rx`.

## Test plan
- CLK_FREQ=1_843_200, BAUD=115200 (DIV=1, 16 clk/bit); frame 0xA5 with `out_ready`=1 → `out_data`=0xA5 and `out_valid` high for 1 clk, no error pulses.
- Low pulse of 4 clk on idle `rx` → back to IDLE, no push, no pulses.
- Frame 0x3C with stop bit held low for 3 bits → `frame_err` pulse, FIFO empty. Then `rx` high followed by frame 0x01 → 0x01 received.
- `out_ready`=0; send 5 frames 0x10..0x14 with FIFO_DEPTH=4 → `overrun` pulses once; draining yields 0x10..0x13 in order.
- With `UART_RX_PARITY_EN` and even parity: 0x07 sent with parity bit 0 → `parity_err` pulse, no push. 0x07 with parity bit 1 → received.
- `rst_n` asserted mid-DATA of a frame → all outputs 0 immediately. The next full frame 0x5A is received correctly.
